// File: rtl/maxnet_result_writer.sv
`default_nettype none
// ============================================================================
// Module   : maxnet_result_writer
// Brief    : Captures the four Maxnet output activations into a readable
//            4x32 buffer and flags the winning (positive nonzero) neuron.
// Revision : 1.0
// ============================================================================
module maxnet_result_writer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        wr_valid_i,
    input  logic [31:0] wr_data_i,
    output logic        wr_ready_o,
    input  logic [1:0]  address_i,
    output logic [31:0] read_data_o,
    output logic [2:0]  count_o,
    output logic        done_o,
    output logic        winner_valid_o,
    output logic [1:0]  winner_idx_o,
    output logic        multi_winner_o
);

    localparam logic [1:0] C_ST_IDLE    = 2'd0;
    localparam logic [1:0] C_ST_COLLECT = 2'd1;
    localparam logic [1:0] C_ST_DONE    = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [2:0]  count_q, count_d;
    logic        done_q, done_d;
    logic        wvalid_q, wvalid_d;
    logic [1:0]  widx_q, widx_d;
    logic        multi_q, multi_d;
    logic [31:0] buf_q [4];
    logic [31:0] buf_d [4];

    logic w_accept;
    logic w_positive;

    assign wr_ready_o = (state_q == C_ST_COLLECT);
    assign w_accept   = wr_valid_i && wr_ready_o;
    // Both signed zeros are excluded; the sign bit alone rejects negatives.
    assign w_positive = !wr_data_i[31] && (wr_data_i[30:0] != 31'd0);

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        count_d  = count_q;
        done_d   = done_q;
        wvalid_d = wvalid_q;
        widx_d   = widx_q;
        multi_d  = multi_q;
        for (int i = 0; i < 4; i++) begin
            buf_d[i] = buf_q[i];
        end

        if (start_i) begin
            // start overrides any write presented in the same cycle
            state_d  = C_ST_COLLECT;
            ptr_d    = 2'd0;
            count_d  = 3'd0;
            done_d   = 1'b0;
            wvalid_d = 1'b0;
            widx_d   = 2'd0;
            multi_d  = 1'b0;
            for (int i = 0; i < 4; i++) begin
                buf_d[i] = 32'd0;
            end
        end else if (w_accept) begin
            buf_d[ptr_q] = wr_data_i;
            ptr_d        = ptr_q + 2'd1;
            count_d      = count_q + 3'd1;
            if (w_positive) begin
                if (!wvalid_q) begin
                    wvalid_d = 1'b1;
                    widx_d   = ptr_q;
                end else begin
                    multi_d  = 1'b1;
                end
            end
            if (ptr_q == 2'd3) begin
                state_d = C_ST_DONE;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= C_ST_IDLE;
            ptr_q    <= 2'd0;
            count_q  <= 3'd0;
            done_q   <= 1'b0;
            wvalid_q <= 1'b0;
            widx_q   <= 2'd0;
            multi_q  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                buf_q[i] <= 32'd0;
            end
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            count_q  <= count_d;
            done_q   <= done_d;
            wvalid_q <= wvalid_d;
            widx_q   <= widx_d;
            multi_q  <= multi_d;
            for (int i = 0; i < 4; i++) begin
                buf_q[i] <= buf_d[i];
            end
        end
    end

    assign read_data_o    = buf_q[address_i];
    assign count_o        = count_q;
    assign done_o         = done_q;
    assign winner_valid_o = wvalid_q;
    assign winner_idx_o   = widx_q;
    assign multi_winner_o = multi_q;

endmodule
`default_nettype wire
